// File: rtl/hp_display_stream.sv
// hp_display_stream
//   Buffered serial driver for the HP dot-matrix display chain, hung off the CPU peripheral bus.
//   The CPU pushes {rs, byte} entries into a FIFO. A frame engine shifts them out MSB-first
//   under HP_CE low. Consecutive bytes with the same rs share one frame. The display latches
//   the data on the rising edge of HP_CE.
//
// Ports
//   CLK, RESET   system clock, synchronous active-high reset
//   WE, A, WD    bus write strobe, register address, write data
//   RD           read data, combinational from A
//   IRQ          IRQ_EN & idle & FIFO empty
//   HP_CE        chip enable (active low)       HP_RS      0 = dot register, 1 = control word
//   HP_CLK       serial clock                   HP_DO      serial data, sampled on HP_CLK rise
//   HP_RESET     display reset (active low)     HP_BLANK   blank
//   HP_OSCSEL    1 = internal oscillator
//
// Register map
//   A=0  W: push {WD[8], WD[7:0]}  R: level at [15:8], {ovf, full, empty, busy} at [3:0]
//   A=1  CTRL: [0] blank, [1] ext osc, [2] display reset, [3] IRQ_EN, [4] FLUSH (write-only)
//   A=2  DIV: half-period is DIV+1 CLK cycles
//   A=3  W: clear ovf
module hp_display_stream #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned DIV_W = 8,
   parameter int unsigned LVL_W = 5
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        WE,
   input  logic [3:0]  A,
   input  logic [31:0] WD,
   output logic [31:0] RD,
   output logic        IRQ,
   output logic        HP_CE,
   output logic        HP_RS,
   output logic        HP_RESET,
   output logic        HP_BLANK,
   output logic        HP_OSCSEL,
   output logic        HP_DO,
   output logic        HP_CLK
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   typedef enum logic [2:0] {StIdle, StSetup, StLow, StHigh, StEnd, StGap} state_e;

   state_e             state_q, state_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic [DIV_W-1:0]   div_q, div_d;
   logic [DIV_W-1:0]   div_act_q, div_act_d;
   logic [3:0]         ctrl_q, ctrl_d;
   logic               ovf_q, ovf_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [7:0]         sreg_q, sreg_d;
   logic [2:0]         bitcnt_q, bitcnt_d;
   logic               rs_q, rs_d;
   logic [8:0]         mem_q [DEPTH];
   logic [8:0]         mem_d [DEPTH];

   logic       wr_fifo, wr_ctrl, wr_div, wr_clr, flush;
   logic       empty, full, busy, tick;
   logic       pop, shift, push_ok;
   logic [8:0] head;
   logic       unused_wd;

   assign unused_wd = ^WD;

   // ---------------------------------------------------------------------------------------------
   // Bus decode and FIFO status
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      wr_fifo = WE && (A == 4'd0);
      wr_ctrl = WE && (A == 4'd1);
      wr_div  = WE && (A == 4'd2);
      wr_clr  = WE && (A == 4'd3);
      flush   = wr_ctrl && WD[4];
      empty   = (level_q == '0);
      full    = (level_q == LVL_W'(DEPTH));
      busy    = (state_q != StIdle) || !empty;
      head    = mem_q[rd_ptr_q];
      // The divider only runs outside IDLE, so a tick can never fire there.
      tick    = (state_q != StIdle) && (cnt_q == div_act_q);
   end

   // ---------------------------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // FSM: next state, plus the pop/shift requests it issues
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      shift   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = StSetup;
            end
         end
         StSetup: if (tick) state_d = StLow;
         StLow:   if (tick) state_d = StHigh;
         StHigh: begin
            if (tick) begin
               if (bitcnt_q != 3'd0) begin
                  shift   = 1'b1;
                  state_d = StLow;
               end else if (!empty && (head[8] == rs_q)) begin
                  // Same register target: chain the next byte into this frame.
                  pop     = 1'b1;
                  state_d = StLow;
               end else begin
                  state_d = StEnd;
               end
            end
         end
         StEnd:   if (tick) state_d = StGap;
         StGap:   if (tick) state_d = StIdle;
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d = StIdle;
         pop     = 1'b0;
         shift   = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      HP_CE  = 1'b1;
      HP_CLK = 1'b0;
      HP_DO  = 1'b0;
      unique case (state_q)
         StSetup, StLow: begin
            HP_CE = 1'b0;
            HP_DO = sreg_q[7];
         end
         StHigh: begin
            HP_CE  = 1'b0;
            HP_CLK = 1'b1;
            HP_DO  = sreg_q[7];
         end
         StEnd:   HP_CE = 1'b0;
         default: ;
      endcase
      HP_RS     = rs_q;
      HP_RESET  = ~ctrl_q[2];
      HP_BLANK  = ctrl_q[0];
      HP_OSCSEL = ~ctrl_q[1];
      IRQ       = ctrl_q[3] && !busy && empty;
   end

   // ---------------------------------------------------------------------------------------------
   // Datapath next state: shift register, divider, FIFO, registers
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      sreg_d   = sreg_q;
      bitcnt_d = bitcnt_q;
      rs_d     = rs_q;
      if (pop) begin
         sreg_d   = head[7:0];
         bitcnt_d = 3'd7;
         rs_d     = head[8];
      end else if (shift) begin
         sreg_d   = {sreg_q[6:0], 1'b0};
         bitcnt_d = bitcnt_q - 3'd1;
      end

      // The active divisor is sampled at every reload so a DIV write never cuts a half-period.
      cnt_d     = cnt_q + DIV_W'(1);
      div_act_d = div_act_q;
      if ((state_q == StIdle) || tick) begin
         cnt_d     = '0;
         div_act_d = div_q;
      end

      push_ok  = wr_fifo && !full && !flush;
      mem_d    = mem_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = WD[8:0];
      end
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      level_d  = level_q;
      if (push_ok && !pop) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop && !push_ok) begin
         level_d = level_q - LVL_W'(1);
      end
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end

      ovf_d = ovf_q;
      if (wr_clr) begin
         ovf_d = 1'b0;
      end
      if (wr_fifo && full) begin
         ovf_d = 1'b1;
      end
      ctrl_d = wr_ctrl ? WD[3:0] : ctrl_q;
      div_d  = wr_div ? WD[DIV_W-1:0] : div_q;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q     <= '0;
         div_q     <= '0;
         div_act_q <= '0;
         ctrl_q    <= '0;
         ovf_q     <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         sreg_q    <= '0;
         bitcnt_q  <= '0;
         rs_q      <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         div_act_q <= div_act_d;
         ctrl_q    <= ctrl_d;
         ovf_q     <= ovf_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         sreg_q    <= sreg_d;
         bitcnt_q  <= bitcnt_d;
         rs_q      <= rs_d;
      end
   end

   // FIFO storage needs no reset; entries are only read below the level count.
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   // ---------------------------------------------------------------------------------------------
   // Read mux
   // ---------------------------------------------------------------------------------------------
   always_comb begin
      RD = '0;
      case (A)
         4'd0: begin
            RD[8 +: LVL_W] = level_q;
            RD[3:0]        = {ovf_q, full, empty, busy};
         end
         4'd1:    RD[3:0]       = ctrl_q;
         4'd2:    RD[DIV_W-1:0] = div_q;
         default: ;
      endcase
   end

endmodule
